// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue with credit-based memory requests,
// redirect flush and discard of in-flight responses.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              IMEM_AW  = 5,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     imem_req,
    output logic [IMEM_AW-1:0]       imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [XLEN-1:0]          imem_rdata,
    output logic                     inst_valid,
    output logic [XLEN-1:0]          inst,
    output logic [XLEN-1:0]          inst_pc,
    input  logic                     inst_ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   count_q, count_d, out_q, out_d, disc_q, disc_d;
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [CW:0]     used;
    logic            gnt, rsp, push, pop;

    // Credits count both queued and in-flight entries, so a response can never find the queue full.
    assign used       = {1'b0, count_q} + {1'b0, out_q};
    assign imem_req   = rst && en && !redirect && (used < (CW+1)'(DEPTH));
    assign imem_addr  = fetch_pc_q[IMEM_AW+1:2];
    assign gnt        = imem_req && imem_gnt;
    assign rsp        = imem_rvalid && (out_q != '0);
    assign push       = rsp && (disc_q == '0) && !redirect;
    assign pop        = inst_valid && inst_ready && !redirect;
    assign inst_valid = count_q != '0;
    assign inst       = inst_valid ? data_q[rd_q] : '0;
    assign inst_pc    = inst_valid ? pc_q[rd_q] : '0;
    assign count      = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        out_d      = out_q;
        disc_d     = disc_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            rsp_pc_d   = redirect_pc & ~XLEN'(3);
            count_d    = '0;
            rd_d       = '0;
            wr_d       = '0;
            out_d      = out_q - CW'(rsp);
            disc_d     = out_q - CW'(rsp);
        end else begin
            fetch_pc_d = gnt ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
            rsp_pc_d   = push ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
            wr_d       = push ? wr_q + PW'(1) : wr_q;
            rd_d       = pop ? rd_q + PW'(1) : rd_q;
            count_d    = count_q + CW'(push) - CW'(pop);
            out_d      = out_q + CW'(gnt) - CW'(rsp);
            disc_d     = (rsp && disc_q != '0) ? disc_q - CW'(1) : disc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            out_q      <= '0;
            disc_q     <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_q] <= imem_rdata;
            pc_q[wr_q]   <= rsp_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vectors plus hand sequences for redirect, backpressure,
// address wrap and asynchronous reset.
module tb_fetch_queue;
    logic        clk, rst, en, redirect, imem_req, imem_gnt, imem_rvalid;
    logic        inst_valid, inst_ready;
    logic [31:0] redirect_pc, imem_rdata, inst, inst_pc;
    logic [4:0]  imem_addr;
    logic [2:0]  count;

    int ncmp = 0;
    int nfail = 0;
    logic       hold = 0;
    logic       stray = 0;
    logic [4:0] rq[$];

    fetch_queue dut (
        .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
        .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready), .count(count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        en, gnt, rdy, req, vld;
        logic [4:0]  addr;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    function automatic logic [31:0] f(input logic [4:0] a);
        return 32'h1300_0000 | {27'd0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic settle();
        imem_rvalid = (!hold && rq.size() > 0) || stray;
        imem_rdata  = rq.size() > 0 ? f(rq[0]) : 32'h0;
        #1;
    endtask

    task automatic tick();
        logic       was, fire;
        logic [4:0] a;
        was  = imem_rvalid;
        fire = imem_req && imem_gnt;
        a    = imem_addr;
        @(posedge clk);
        #1;
        if (was && rq.size() > 0) void'(rq.pop_front());
        if (fire) rq.push_back(a);
    endtask

    task automatic do_reset();
        rst = 0; en = 0; redirect = 0; redirect_pc = 0; imem_gnt = 0; inst_ready = 0;
        hold = 0; stray = 0; imem_rvalid = 0; imem_rdata = 0;
        rq.delete();
        @(posedge clk);
        #3 rst = 1;
    endtask

    vec_t tv[12];
    int   grants;

    initial begin
        tv[0]  = '{1, 1, 1, 1, 0, 5'd0, 32'h00, 3'd0};
        tv[1]  = '{1, 1, 1, 1, 0, 5'd1, 32'h00, 3'd0};
        tv[2]  = '{1, 1, 1, 1, 1, 5'd2, 32'h00, 3'd1};
        tv[3]  = '{1, 1, 1, 1, 1, 5'd3, 32'h04, 3'd1};
        tv[4]  = '{1, 1, 1, 1, 1, 5'd4, 32'h08, 3'd1};
        tv[5]  = '{1, 1, 1, 1, 1, 5'd5, 32'h0C, 3'd1};
        tv[6]  = '{0, 1, 1, 0, 1, 5'd6, 32'h10, 3'd1};
        tv[7]  = '{0, 1, 1, 0, 1, 5'd6, 32'h14, 3'd1};
        tv[8]  = '{0, 1, 1, 0, 0, 5'd6, 32'h00, 3'd0};
        tv[9]  = '{1, 1, 0, 1, 0, 5'd6, 32'h00, 3'd0};
        tv[10] = '{1, 1, 0, 1, 0, 5'd7, 32'h00, 3'd0};
        tv[11] = '{1, 1, 0, 1, 1, 5'd8, 32'h18, 3'd1};

        rst = 0; en = 1; redirect = 0; redirect_pc = 0; imem_gnt = 1; inst_ready = 1;
        imem_rvalid = 0; imem_rdata = 0;
        #2;
        chk("rst_req", {31'd0, imem_req}, 0);
        chk("rst_valid", {31'd0, inst_valid}, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_count", {29'd0, count}, 0);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            en = tv[i].en; imem_gnt = tv[i].gnt; inst_ready = tv[i].rdy;
            settle();
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, tv[i].req});
            chk($sformatf("v%0d_addr", i), {27'd0, imem_addr}, {27'd0, tv[i].addr});
            chk($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, tv[i].vld});
            chk($sformatf("v%0d_pc", i), inst_pc, tv[i].pc);
            chk($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, tv[i].cnt});
            chk($sformatf("v%0d_inst", i), inst, tv[i].vld ? f(tv[i].pc[6:2]) : 32'h0);
            tick();
        end

        do_reset();
        en = 1; imem_gnt = 1; inst_ready = 0;
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (imem_req && imem_gnt) grants++;
            tick();
        end
        settle();
        chk("bp_grants", grants, 4);
        chk("bp_req_full", {31'd0, imem_req}, 0);
        chk("bp_count_full", {29'd0, count}, 4);
        chk("bp_head_pc", inst_pc, 0);
        inst_ready = 1;
        settle();
        tick();
        inst_ready = 0;
        settle();
        chk("bp_req_after_pop", {31'd0, imem_req}, 1);
        chk("bp_count_after_pop", {29'd0, count}, 3);
        tick();
        settle();
        chk("bp_req_refull", {31'd0, imem_req}, 0);

        do_reset();
        en = 1; imem_gnt = 1; inst_ready = 1; hold = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            tick();
        end
        redirect = 1; redirect_pc = 32'h40;
        settle();
        chk("rd3_req_during", {31'd0, imem_req}, 0);
        tick();
        redirect = 0; hold = 0;
        settle();
        chk("rd3_count", {29'd0, count}, 0);
        chk("rd3_addr", {27'd0, imem_addr}, 16);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rd3_drop%0d_valid", i), {31'd0, inst_valid}, 0);
            tick();
            settle();
        end
        chk("rd3_valid", {31'd0, inst_valid}, 1);
        chk("rd3_pc", inst_pc, 32'h40);
        chk("rd3_inst", inst, f(5'd16));

        do_reset();
        en = 1; imem_gnt = 1; inst_ready = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            tick();
        end
        redirect = 1; redirect_pc = 32'h23;
        settle();
        chk("rdv_pre_valid", {31'd0, inst_valid}, 1);
        chk("rdv_pre_rvalid", {31'd0, imem_rvalid}, 1);
        tick();
        redirect = 0;
        settle();
        chk("rdv_valid", {31'd0, inst_valid}, 0);
        chk("rdv_count", {29'd0, count}, 0);
        chk("rdv_req", {31'd0, imem_req}, 1);
        chk("rdv_addr", {27'd0, imem_addr}, 8);
        tick();
        settle();
        chk("rdv_valid2", {31'd0, inst_valid}, 0);
        tick();
        settle();
        chk("rdv_pc", inst_pc, 32'h20);
        chk("rdv_inst", inst, f(5'd8));

        do_reset();
        redirect = 1; redirect_pc = 32'h78;
        settle();
        tick();
        redirect = 0; en = 1; imem_gnt = 1; inst_ready = 1;
        settle();
        chk("wrap_addr30", {27'd0, imem_addr}, 30);
        tick();
        settle();
        chk("wrap_addr31", {27'd0, imem_addr}, 31);
        tick();
        settle();
        chk("wrap_addr0", {27'd0, imem_addr}, 0);
        chk("wrap_pc78", inst_pc, 32'h78);
        tick();
        settle();
        chk("wrap_pc7c", inst_pc, 32'h7C);
        tick();
        settle();
        chk("wrap_pc80", inst_pc, 32'h80);
        chk("wrap_inst80", inst, f(5'd0));
        tick();

        #2 rst = 0;
        #1;
        chk("arst_valid", {31'd0, inst_valid}, 0);
        chk("arst_req", {31'd0, imem_req}, 0);
        chk("arst_count", {29'd0, count}, 0);
        imem_rvalid = 0;
        rq.delete();
        @(posedge clk);
        #2 rst = 1;
        stray = 1;
        settle();
        chk("arst_restart_req", {31'd0, imem_req}, 1);
        chk("arst_restart_addr", {27'd0, imem_addr}, 0);
        tick();
        stray = 0;
        settle();
        chk("arst_stray_ignored", {29'd0, count}, 0);
        tick();
        settle();
        chk("arst_first_valid", {31'd0, inst_valid}, 1);
        chk("arst_first_pc", inst_pc, 0);
        chk("arst_first_inst", inst, f(5'd0));
        chk("arst_first_count", {29'd0, count}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, instruction and PC width.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-003 Parameter IMEM_AW, default 5, instruction-memory word-address width.
REQ-004 Parameter RESET_PC, default 0, PC after reset; word aligned.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  fetch enable; gates new memory requests only.
REQ-008 redirect  in  1  jump/branch taken; flush and restart at redirect_pc.
REQ-009 redirect_pc  in  XLEN  target PC; bits [1:0] forced to 0 internally.
REQ-010 imem_req  out  1  memory request valid.
REQ-011 imem_addr  out  IMEM_AW  word address, fetch_pc[IMEM_AW+1:2], wraps modulo 2^IMEM_AW.
REQ-012 imem_gnt  in  1  request accepted this cycle when imem_req && imem_gnt.
REQ-013 imem_rvalid  in  1  in-order read response valid, any latency >= 1 cycle.
REQ-014 imem_rdata  in  XLEN  response instruction.
REQ-015 inst_valid  out  1  queue head valid (count != 0).
REQ-016 inst  out  XLEN  head instruction; 0 when empty.
REQ-017 inst_pc  out  XLEN  head PC; 0 when empty.
REQ-018 inst_ready  in  1  consumer pops head when inst_valid && inst_ready.
REQ-019 count  out  clog2(DEPTH)+1  queue occupancy.

Function
REQ-020 State: fetch_pc, rsp_pc, outstanding (0..DEPTH), discard (0..DEPTH), circular buffer with rd/wr pointers and count.
REQ-021 imem_req = en && !redirect && (count + outstanding < DEPTH); credit scheme guarantees no push when full.
REQ-022 Grant: fetch_pc += 4 (wraps at 2^XLEN), outstanding += 1.
REQ-023 imem_rvalid with outstanding == 0 is ignored.
REQ-024 Response with discard > 0: data dropped, discard -= 1, outstanding -= 1.
REQ-025 Response with discard == 0: push {rsp_pc, imem_rdata}, rsp_pc += 4, outstanding -= 1; visible on inst_valid the next cycle (1-cycle rvalid-to-inst_valid latency).
REQ-026 Grant and response in same cycle: outstanding unchanged.
REQ-027 Push and pop in same cycle: count unchanged, both pointers advance.
REQ-028 Pointers wrap modulo DEPTH.
REQ-029 Redirect (priority over all else): count, pointers -> 0; fetch_pc, rsp_pc <- redirect_pc; discard <- outstanding - (imem_rvalid ? 1 : 0) (in-flight responses dropped, including any arriving that cycle); simultaneous pop and push ignored.
REQ-030 Redirect while discard > 0: discard recomputed per REQ-029 (accumulates all in-flight).
REQ-031 Back-to-back redirects: each restarts; last one wins.
REQ-032 en low: no new requests; outstanding responses still accepted/discarded; queue still drains.

Reset
REQ-033 rst low asynchronously sets fetch_pc, rsp_pc = RESET_PC; outstanding, discard, count, pointers = 0; imem_req, inst_valid = 0; inst, inst_pc = 0.
REQ-034 After rst release, first request is issued in the first cycle with en high, imem_addr = RESET_PC[IMEM_AW+1:2].
REQ-035 Reset mid-operation discards all in-flight responses; memory-side responses after release with outstanding == 0 ignored per REQ-023.

Verification
REQ-036 Stream: DEPTH=4, gnt=1, 1-cycle rvalid, inst_ready=1 -> inst_pc 0,4,8,12,... one per cycle after 2-cycle fill.
REQ-037 Backpressure: inst_ready=0 -> exactly 4 grants then imem_req=0, count=4; one pop -> one new grant next cycle.
REQ-038 Redirect with 3 outstanding, no rvalid that cycle, redirect_pc=0x40 -> next 3 responses dropped, first inst_pc=0x40, count=0 at redirect+1.
REQ-039 Redirect coinciding with rvalid and pop -> that response dropped, discard = outstanding-1, queue empty next cycle.
REQ-040 Address wrap: IMEM_AW=5, fetch_pc=0x7C -> imem_addr 31 then 0; inst_pc continues 0x80.
REQ-041 Async reset asserted mid-stream, between edges -> inst_valid, imem_req, count low immediately; restart at RESET_PC.
